// File: rtl/muldiv_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op codes, FSM states, iteration count.
package muldiv_pkg;

  localparam int unsigned MULDIV_ITERS = 32;

  typedef enum logic [2:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// Divide support is compiled in only when MULDIV_DIV_EN is defined.
module muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(MULDIV_ITERS);
`ifdef MULDIV_DIV_EN
  localparam int unsigned SUM_W = W + 2;
`else
  localparam int unsigned SUM_W = W + 1;
`endif

  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic is_signed);
    return (is_signed && x[W-1]) ? W'(~x + 1'b1) : x;
  endfunction

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] x);
    return W'(~x + 1'b1);
  endfunction

  md_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   mag_b_q, mag_b_d;
  logic           neg_quot_q, neg_quot_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
`ifdef MULDIV_DIV_EN
  logic           neg_rem_q, neg_rem_d;
  logic           is_div_q, is_div_d;
`endif

  logic [W:0]       add_x, add_y;
  logic             add_cin;
  logic [SUM_W-1:0] add_sum;
  logic [2*W-1:0]   prod;
  logic             signed_op;
  md_op_e           op_e;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mag_b_d    = mag_b_q;
    neg_quot_d = neg_quot_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    signed_op  = 1'b0;
    op_e       = md_op_e'(op);
`ifdef MULDIV_DIV_EN
    neg_rem_d  = neg_rem_q;
    is_div_d   = is_div_q;
`endif

    // Shared adder: shift-add in MUL, 33-bit trial subtract (carry = no borrow) in DIV.
    add_x   = {1'b0, acc_q[2*W-1:W]};
    add_y   = acc_q[0] ? {1'b0, mag_b_q} : '0;
    add_cin = 1'b0;
`ifdef MULDIV_DIV_EN
    if (state_q == ST_DIV) begin
      add_x   = acc_q[2*W-1:W-1];
      add_y   = ~{1'b0, mag_b_q};
      add_cin = 1'b1;
    end
`endif
    add_sum = SUM_W'({1'b0, add_x} + {1'b0, add_y} + (W+2)'(add_cin));
    prod    = neg_quot_q ? (2*W)'(~acc_q + 1'b1) : acc_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op_e)
            MD_MULT, MD_MULTU: begin
              signed_op  = (op_e == MD_MULT);
              acc_d      = {{W{1'b0}}, mag(b, signed_op)};
              mag_b_d    = mag(a, signed_op);
              neg_quot_d = signed_op & (a[W-1] ^ b[W-1]);
              cnt_d      = CNT_W'(MULDIV_ITERS - 1);
              busy_d     = 1'b1;
              state_d    = ST_MUL;
`ifdef MULDIV_DIV_EN
              is_div_d   = 1'b0;
`endif
            end
`ifdef MULDIV_DIV_EN
            MD_DIV, MD_DIVU: begin
              signed_op  = (op_e == MD_DIV);
              acc_d      = {{W{1'b0}}, mag(a, signed_op)};
              mag_b_d    = mag(b, signed_op);
              neg_quot_d = signed_op & (a[W-1] ^ b[W-1]);
              neg_rem_d  = signed_op & a[W-1];
              cnt_d      = CNT_W'(MULDIV_ITERS - 1);
              busy_d     = 1'b1;
              is_div_d   = 1'b1;
              state_d    = ST_DIV;
            end
`endif
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        acc_d = {add_sum[W:0], acc_q[W-1:1]};
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
`ifdef MULDIV_DIV_EN
      ST_DIV: begin
        if (add_sum[W+1]) acc_d = {add_sum[W-1:0], acc_q[W-2:0], 1'b1};
        else              acc_d = {acc_q[2*W-2:0], 1'b0};
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
`endif
      ST_FIX: begin
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
          lo_d = neg_quot_q ? neg_w(acc_q[W-1:0])   : acc_q[W-1:0];
          hi_d = neg_rem_q  ? neg_w(acc_q[2*W-1:W]) : acc_q[2*W-1:W];
        end else begin
          hi_d = prod[2*W-1:W];
          lo_d = prod[W-1:0];
        end
`else
        hi_d = prod[2*W-1:W];
        lo_d = prod[W-1:0];
`endif
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mag_b_q    <= '0;
      neg_quot_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_rem_q  <= 1'b0;
      is_div_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mag_b_q    <= mag_b_d;
      neg_quot_q <= neg_quot_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef MULDIV_DIV_EN
      neg_rem_q  <= neg_rem_d;
      is_div_q   <= is_div_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// Directed self-checking bench for muldiv; divide vectors run only when MULDIV_DIV_EN is defined.
module tb_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int vec_cnt = 0;
  int err_cnt = 0;

  muldiv #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one op at the current time; returns once done is seen (or the bound expires).
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int cycles, output int busy_cycles, output bit timed_out);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = MD_NOP;
    cycles = 1; busy_cycles = 0;
    while (done !== 1'b1 && cycles < 40) begin
      if (busy === 1'b1) busy_cycles++;
      @(posedge clk); #1;
      cycles++;
    end
    timed_out = (done !== 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = MD_NOP; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++; if (hi !== 32'h0)   begin err_cnt++; $display("FAIL reset_hi: got %h want %h", hi, 32'h0); end
    vec_cnt++; if (lo !== 32'h0)   begin err_cnt++; $display("FAIL reset_lo: got %h want %h", lo, 32'h0); end
    vec_cnt++; if (busy !== 1'b0)  begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec_cnt++; if (done !== 1'b0)  begin err_cnt++; $display("FAIL reset_done: got %b want 0", done); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_multu_max();
    int cyc, bcyc; bit to;
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bcyc, to);
    vec_cnt++; if (to)             begin err_cnt++; $display("FAIL multu_timeout: done not seen after %0d cycles", cyc); end
    vec_cnt++; if (cyc != 34)      begin err_cnt++; $display("FAIL multu_latency: got %0d want 34", cyc); end
    vec_cnt++; if (bcyc != 33)     begin err_cnt++; $display("FAIL multu_busy_cycles: got %0d want 33", bcyc); end
    vec_cnt++; if (busy !== 1'b0)  begin err_cnt++; $display("FAIL multu_busy_in_done: got %b want 0", busy); end
    vec_cnt++; if (hi !== 32'hFFFF_FFFE) begin err_cnt++; $display("FAIL multu_hi: got %h want %h", hi, 32'hFFFF_FFFE); end
    vec_cnt++; if (lo !== 32'h0000_0001) begin err_cnt++; $display("FAIL multu_lo: got %h want %h", lo, 32'h0000_0001); end
    @(posedge clk); #1;
    vec_cnt++; if (done !== 1'b0)  begin err_cnt++; $display("FAIL multu_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_mult_signed_b2b();
    int cyc, bcyc; bit to;
    run_op(MD_MULT, 32'hFFFF_FFF9, 32'd3, cyc, bcyc, to);
    vec_cnt++; if (to || cyc != 34) begin err_cnt++; $display("FAIL mult_latency: got %0d want 34", cyc); end
    vec_cnt++; if (hi !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL mult_neg_hi: got %h want %h", hi, 32'hFFFF_FFFF); end
    vec_cnt++; if (lo !== 32'hFFFF_FFEB) begin err_cnt++; $display("FAIL mult_neg_lo: got %h want %h", lo, 32'hFFFF_FFEB); end
    // Issued in the done cycle: must be accepted with no bubble.
    run_op(MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bcyc, to);
    vec_cnt++; if (to || cyc != 34) begin err_cnt++; $display("FAIL b2b_latency: got %0d want 34", cyc); end
    vec_cnt++; if (bcyc != 33)     begin err_cnt++; $display("FAIL b2b_busy_cycles: got %0d want 33", bcyc); end
    vec_cnt++; if (hi !== 32'h0)   begin err_cnt++; $display("FAIL b2b_hi: got %h want %h", hi, 32'h0); end
    vec_cnt++; if (lo !== 32'h1)   begin err_cnt++; $display("FAIL b2b_lo: got %h want %h", lo, 32'h1); end
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_divide();
    int cyc, bcyc; bit to;
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, cyc, bcyc, to);
    vec_cnt++; if (to || cyc != 34) begin err_cnt++; $display("FAIL div_latency: got %0d want 34", cyc); end
    vec_cnt++; if (lo !== 32'hFFFF_FFFD) begin err_cnt++; $display("FAIL div_neg_lo: got %h want %h", lo, 32'hFFFF_FFFD); end
    vec_cnt++; if (hi !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL div_neg_hi: got %h want %h", hi, 32'hFFFF_FFFF); end
    run_op(MD_DIVU, 32'd100, 32'd0, cyc, bcyc, to);
    vec_cnt++; if (to)             begin err_cnt++; $display("FAIL divu_zero_timeout: cycles %0d", cyc); end
    vec_cnt++; if (lo !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL divu_zero_lo: got %h want %h", lo, 32'hFFFF_FFFF); end
    vec_cnt++; if (hi !== 32'd100) begin err_cnt++; $display("FAIL divu_zero_hi: got %h want %h", hi, 32'd100); end
    run_op(MD_DIV, 32'hFFFF_FFF0, 32'd0, cyc, bcyc, to);
    vec_cnt++; if (lo !== 32'h1)   begin err_cnt++; $display("FAIL div_zero_neg_lo: got %h want %h", lo, 32'h1); end
    vec_cnt++; if (hi !== 32'hFFFF_FFF0) begin err_cnt++; $display("FAIL div_zero_neg_hi: got %h want %h", hi, 32'hFFFF_FFF0); end
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bcyc, to);
    vec_cnt++; if (lo !== 32'h8000_0000) begin err_cnt++; $display("FAIL div_ovf_lo: got %h want %h", lo, 32'h8000_0000); end
    vec_cnt++; if (hi !== 32'h0)   begin err_cnt++; $display("FAIL div_ovf_hi: got %h want %h", hi, 32'h0); end
    run_op(MD_DIVU, 32'd1000, 32'd7, cyc, bcyc, to);
    vec_cnt++; if (lo !== 32'd142) begin err_cnt++; $display("FAIL divu_lo: got %h want %h", lo, 32'd142); end
    vec_cnt++; if (hi !== 32'd6)   begin err_cnt++; $display("FAIL divu_hi: got %h want %h", hi, 32'd6); end
  endtask
`else
  task automatic test_div_disabled();
    start = 1'b1; op = MD_MTLO; a = 32'h0000_0055; b = '0;
    @(posedge clk); #1;
    start = 1'b1; op = MD_DIVU; a = 32'd100; b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; op = MD_NOP;
    for (int i = 0; i < 3; i++) begin
      vec_cnt++; if (busy !== 1'b0 || done !== 1'b0)
        begin err_cnt++; $display("FAIL divu_nop_flags: busy %b done %b want 0 0", busy, done); end
      @(posedge clk); #1;
    end
    vec_cnt++; if (lo !== 32'h0000_0055) begin err_cnt++; $display("FAIL divu_nop_lo: got %h want %h", lo, 32'h55); end
    vec_cnt++; if (hi !== 32'h0)   begin err_cnt++; $display("FAIL divu_nop_hi: got %h want %h", hi, 32'h0); end
  endtask
`endif

  task automatic test_mt_busy();
    int n;
    start = 1'b1; op = MD_MTHI; a = 32'h0; b = '0;
    @(posedge clk); #1;
    start = 1'b1; op = MD_MULTU; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b1; op = MD_MTHI; a = 32'h1234;
    @(posedge clk); #1;
    start = 1'b0; op = MD_NOP;
    vec_cnt++; if (hi !== 32'h0)   begin err_cnt++; $display("FAIL mthi_busy_ignored: got %h want %h", hi, 32'h0); end
    n = 0;
    while (done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    vec_cnt++; if (done !== 1'b1)  begin err_cnt++; $display("FAIL mt_busy_timeout: done not seen"); end
    vec_cnt++; if (hi !== 32'h0)   begin err_cnt++; $display("FAIL mt_busy_hi: got %h want %h", hi, 32'h0); end
    vec_cnt++; if (lo !== 32'd15)  begin err_cnt++; $display("FAIL mt_busy_lo: got %h want %h", lo, 32'd15); end
    start = 1'b1; op = MD_MTLO; a = 32'hABCD;
    @(posedge clk); #1;
    start = 1'b0; op = MD_NOP;
    vec_cnt++; if (lo !== 32'hABCD) begin err_cnt++; $display("FAIL mtlo_idle: got %h want %h", lo, 32'hABCD); end
    vec_cnt++; if (busy !== 1'b0 || done !== 1'b0)
      begin err_cnt++; $display("FAIL mtlo_flags: busy %b done %b want 0 0", busy, done); end
  endtask

  task automatic test_reset_mid();
    int cyc, bcyc; bit to;
    start = 1'b1; op = MD_MTHI; a = 32'h5A5A;
    @(posedge clk); #1;
    start = 1'b1; op = MD_MULT; a = 32'h1234_5678; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; op = MD_NOP;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vec_cnt++; if (hi !== 32'h0)   begin err_cnt++; $display("FAIL rst_mid_hi: got %h want %h", hi, 32'h0); end
    vec_cnt++; if (lo !== 32'h0)   begin err_cnt++; $display("FAIL rst_mid_lo: got %h want %h", lo, 32'h0); end
    vec_cnt++; if (busy !== 1'b0)  begin err_cnt++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(MD_MULTU, 32'd6, 32'd7, cyc, bcyc, to);
    vec_cnt++; if (to || lo !== 32'd42 || hi !== 32'h0)
      begin err_cnt++; $display("FAIL post_rst_mul: got %h_%h want %h_%h", hi, lo, 32'h0, 32'd42); end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_mult_signed_b2b();
`ifdef MULDIV_DIV_EN
    test_divide();
`else
    test_div_disabled();
`endif
    test_mt_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
